// File: rtl/luu_lap_gpg_pkg.sv
// Shared definitions for the lap/split memory: field limits, time width,
// FSM encoding, lap-word packing and the per-field borrow subtract helpers.
package luu_lap_gpg_pkg;

    localparam int TIME_W = 7;
    localparam int WORD_W = 4 * TIME_W;

    // Modulus of each time field, lowest field first in borrow order
    localparam logic [TIME_W-1:0] LIM_PTGIAY = 7'd100;
    localparam logic [TIME_W-1:0] LIM_GIAY   = 7'd60;
    localparam logic [TIME_W-1:0] LIM_PHUT   = 7'd60;
    localparam logic [TIME_W-1:0] LIM_GIO    = 7'd100;

    typedef enum logic {
        ST_LIVE = 1'b0,
        ST_VIEW = 1'b1
    } state_t;

    // 28-bit lap word, hours in the top bits, centiseconds in the bottom bits
    typedef struct packed {
        logic [TIME_W-1:0] gio;
        logic [TIME_W-1:0] phut;
        logic [TIME_W-1:0] giay;
        logic [TIME_W-1:0] ptgiay;
    } lap_word_t;

    // 1 when a - b - bin goes below zero for this field
    function automatic logic field_borrow(input logic [TIME_W-1:0] a,
                                         input logic [TIME_W-1:0] b,
                                         input logic              bin);
        return ({1'b0, a} < ({1'b0, b} + {{TIME_W{1'b0}}, bin}));
    endfunction

    // a - b - bin folded back into 0..lim-1; modular 7-bit arithmetic is exact
    // because every field value and limit fits in 7 bits
    function automatic logic [TIME_W-1:0] sub_field(input logic [TIME_W-1:0] a,
                                                    input logic [TIME_W-1:0] b,
                                                    input logic              bin,
                                                    input logic [TIME_W-1:0] lim);
        logic [TIME_W-1:0] d;
        d = a - b - {{(TIME_W-1){1'b0}}, bin};
        if (field_borrow(a, b, bin)) begin
            d = d + lim;
        end
        return d;
    endfunction

endpackage

// File: rtl/tru_thoigian.sv
// Combinational mixed-radix subtractor: o_diff = i_a - i_b over
// centiseconds/seconds/minutes with borrow, hours wrapping mod 100.
module tru_thoigian
    import luu_lap_gpg_pkg::*;
(
    input  lap_word_t i_a,
    input  lap_word_t i_b,
    output lap_word_t o_diff
);

    logic w_b_cs;
    logic w_b_s;
    logic w_b_m;

    assign w_b_cs = field_borrow(i_a.ptgiay, i_b.ptgiay, 1'b0);
    assign w_b_s  = field_borrow(i_a.giay,   i_b.giay,   w_b_cs);
    assign w_b_m  = field_borrow(i_a.phut,   i_b.phut,   w_b_s);

    // Ripple the borrow chain from centiseconds up to hours
    always_comb begin
        o_diff.ptgiay = sub_field(i_a.ptgiay, i_b.ptgiay, 1'b0,   LIM_PTGIAY);
        o_diff.giay   = sub_field(i_a.giay,   i_b.giay,   w_b_cs, LIM_GIAY);
        o_diff.phut   = sub_field(i_a.phut,   i_b.phut,   w_b_s,  LIM_PHUT);
        o_diff.gio    = sub_field(i_a.gio,    i_b.gio,    w_b_m,  LIM_GIO);
    end

endmodule

// File: rtl/luu_lap_gpg.sv
// Lap/split memory for the stopwatch: captures the live time on lap_p,
// stores up to DEPTH laps and drives the display with live time or a
// recalled lap (absolute or split). The LIVE/VIEW state is visible on viewing.
//
// Handshake: all control inputs are single-cycle pulses with no ready/ack;
// a pulse acts on the rising edge where it is high. Priority is
// clr_p > lap_p > view_p > next_p/prev_p, except lap_p and view_p may act
// together (VIEW entry then uses the pre-increment lap count).
module luu_lap_gpg
    import luu_lap_gpg_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
)
(
    input  logic              ckht,
    input  logic              rst_n,
    input  logic              lap_p,
    input  logic              view_p,
    input  logic              next_p,
    input  logic              prev_p,
    input  logic              clr_p,
    input  logic              split_md,
    input  logic [TIME_W-1:0] ptgiay_in,
    input  logic [TIME_W-1:0] giay_in,
    input  logic [TIME_W-1:0] phut_in,
    input  logic [TIME_W-1:0] gio_in,
    output logic [TIME_W-1:0] ptgiay,
    output logic [TIME_W-1:0] giay,
    output logic [TIME_W-1:0] phut,
    output logic [TIME_W-1:0] gio,
    output logic              viewing,
    output logic [AW-1:0]     lap_idx,
    output logic [AW:0]       lap_cnt,
    output logic              full,
    output logic              ovf
);

    localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        r_state;
    state_t        w_state_nx;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nx;
    logic [AW-1:0] w_last;
    logic [AW-1:0] w_idx_prv;
    logic [AW:0]   r_cnt;
    logic [AW:0]   w_cnt_inc;
    logic          r_ovf;
    logic          r_full;
    logic          w_full_now;
    logic          w_wr_en;
    logic          w_move;

    lap_word_t     r_mem [DEPTH];
    lap_word_t     w_live;
    lap_word_t     w_cur;
    lap_word_t     w_prv;
    lap_word_t     w_diff;
    lap_word_t     w_disp_nx;
    lap_word_t     r_disp;

    assign w_live     = '{gio: gio_in, phut: phut_in, giay: giay_in, ptgiay: ptgiay_in};
    assign w_full_now = (r_cnt == CNT_MAX);
    assign w_wr_en    = lap_p && !clr_p && !w_full_now;
    assign w_cnt_inc  = r_cnt + CNT_ONE;
    // Newest lap index; the low bits of DEPTH are zero, so a full memory
    // wraps correctly to DEPTH-1
    assign w_last     = r_cnt[AW-1:0] - IDX_ONE;
    assign w_idx_prv  = r_idx - IDX_ONE;
    assign w_move     = next_p ^ prev_p;

    // Lap storage: no reset, stale words are unreachable while lap_cnt is 0
    always_ff @(posedge ckht) begin
        if (w_wr_en) begin
            r_mem[r_cnt[AW-1:0]] <= w_live;
        end
    end

    // Lap count, full flag and sticky overflow
    always_ff @(posedge ckht or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_full <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (clr_p) begin
            r_cnt  <= '0;
            r_full <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (lap_p) begin
            if (w_full_now) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt  <= w_cnt_inc;
                r_full <= (w_cnt_inc == CNT_MAX);
            end
        end
    end

    // FSM state register with the shown-lap index
    always_ff @(posedge ckht or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LIVE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
        end
    end

    // FSM next state: clear, view toggle, then lap navigation
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        if (clr_p) begin
            w_state_nx = ST_LIVE;
            w_idx_nx   = '0;
        end else if (view_p) begin
            if (r_state == ST_VIEW) begin
                w_state_nx = ST_LIVE;
                w_idx_nx   = '0;
            end else if (r_cnt != '0) begin
                w_state_nx = ST_VIEW;
                w_idx_nx   = w_last;
            end
        end else if (!lap_p && (r_state == ST_VIEW) && w_move) begin
            if (next_p) begin
                w_idx_nx = (r_idx == w_last) ? '0 : (r_idx + IDX_ONE);
            end else begin
                w_idx_nx = (r_idx == '0) ? w_last : w_idx_prv;
            end
        end
    end

    assign w_cur = r_mem[r_idx];
    assign w_prv = (r_idx == '0) ? '0 : r_mem[w_idx_prv];

    tru_thoigian u_tru (
        .i_a    (w_cur),
        .i_b    (w_prv),
        .o_diff (w_diff)
    );

    // FSM output: pick live time, stored lap or split for the display
    always_comb begin
        w_disp_nx = w_live;
        if (r_state == ST_VIEW) begin
            w_disp_nx = split_md ? w_diff : w_cur;
        end
    end

    // Display register feeding the BCD stage
    always_ff @(posedge ckht or negedge rst_n) begin
        if (!rst_n) begin
            r_disp <= '0;
        end else begin
            r_disp <= w_disp_nx;
        end
    end

    assign ptgiay  = r_disp.ptgiay;
    assign giay    = r_disp.giay;
    assign phut    = r_disp.phut;
    assign gio     = r_disp.gio;
    assign viewing = (r_state == ST_VIEW);
    assign lap_idx = r_idx;
    assign lap_cnt = r_cnt;
    assign full    = r_full;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_luu_lap_gpg.sv
// Bench for luu_lap_gpg: directed scenarios plus random pulses, checked
// every cycle against a queue-of-laps model working in total centiseconds.
module tb_luu_lap_gpg;

    localparam int DEPTH  = 8;
    localparam int AW     = 3;
    localparam int WRAP_CS = 100 * 60 * 60 * 100;

    logic       ckht = 1'b0;
    logic       rst_n = 1'b0;
    logic       lap_p = 1'b0;
    logic       view_p = 1'b0;
    logic       next_p = 1'b0;
    logic       prev_p = 1'b0;
    logic       clr_p = 1'b0;
    logic       split_md = 1'b0;
    logic [6:0] ptgiay_in = '0;
    logic [6:0] giay_in = '0;
    logic [6:0] phut_in = '0;
    logic [6:0] gio_in = '0;
    logic [6:0] ptgiay;
    logic [6:0] giay;
    logic [6:0] phut;
    logic [6:0] gio;
    logic       viewing;
    logic [AW-1:0] lap_idx;
    logic [AW:0]   lap_cnt;
    logic       full;
    logic       ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_laps[$];
    bit m_view;
    int m_idx;
    bit m_ovf;

    // Clock
    always #5 ckht = ~ckht;

    luu_lap_gpg #(.DEPTH(DEPTH), .AW(AW)) dut (
        .ckht      (ckht),
        .rst_n     (rst_n),
        .lap_p     (lap_p),
        .view_p    (view_p),
        .next_p    (next_p),
        .prev_p    (prev_p),
        .clr_p     (clr_p),
        .split_md  (split_md),
        .ptgiay_in (ptgiay_in),
        .giay_in   (giay_in),
        .phut_in   (phut_in),
        .gio_in    (gio_in),
        .ptgiay    (ptgiay),
        .giay      (giay),
        .phut      (phut),
        .gio       (gio),
        .viewing   (viewing),
        .lap_idx   (lap_idx),
        .lap_cnt   (lap_cnt),
        .full      (full),
        .ovf       (ovf)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_disp(input string tag, input int t);
        check_val({tag, "_cs"}, int'(ptgiay), t % 100);
        check_val({tag, "_s"},  int'(giay),   (t / 100) % 60);
        check_val({tag, "_m"},  int'(phut),   (t / 6000) % 60);
        check_val({tag, "_h"},  int'(gio),    (t / 360000) % 100);
    endtask

    function automatic int split_of(input int idx);
        int d;
        d = m_laps[idx] - ((idx == 0) ? 0 : m_laps[idx - 1]);
        if (d < 0) d += WRAP_CS;
        return d;
    endfunction

    // Drive one cycle of inputs, advance the model and check all outputs
    task automatic do_cycle(input bit lap, input bit view, input bit nx, input bit pv,
                            input bit clr, input bit sp, input int t_live);
        int exp_t;
        int pre_cnt;
        lap_p     = lap;
        view_p    = view;
        next_p    = nx;
        prev_p    = pv;
        clr_p     = clr;
        split_md  = sp;
        ptgiay_in = 7'(t_live % 100);
        giay_in   = 7'((t_live / 100) % 60);
        phut_in   = 7'((t_live / 6000) % 60);
        gio_in    = 7'((t_live / 360000) % 100);
        @(posedge ckht);
        if (m_view) exp_t = sp ? split_of(m_idx) : m_laps[m_idx];
        else        exp_t = t_live;
        if (clr) begin
            m_laps.delete();
            m_view = 0;
            m_idx  = 0;
            m_ovf  = 0;
        end else begin
            pre_cnt = m_laps.size();
            if (lap) begin
                if (pre_cnt < DEPTH) m_laps.push_back(t_live);
                else                 m_ovf = 1;
            end
            if (view) begin
                if (m_view) begin
                    m_view = 0;
                    m_idx  = 0;
                end else if (pre_cnt > 0) begin
                    m_view = 1;
                    m_idx  = pre_cnt - 1;
                end
            end else if (!lap && m_view && (nx != pv)) begin
                if (nx) m_idx = (m_idx + 1) % pre_cnt;
                else    m_idx = (m_idx + pre_cnt - 1) % pre_cnt;
            end
        end
        @(negedge ckht);
        check_disp("disp", exp_t);
        check_val("viewing", int'(viewing), int'(m_view));
        check_val("lap_idx", int'(lap_idx), m_idx);
        check_val("lap_cnt", int'(lap_cnt), m_laps.size());
        check_val("full",    int'(full),    int'(m_laps.size() == DEPTH));
        check_val("ovf",     int'(ovf),     int'(m_ovf));
        lap_p  = 0;
        view_p = 0;
        next_p = 0;
        prev_p = 0;
        clr_p  = 0;
    endtask

    initial begin
        int t;
        // Reset with live 00:01:02.34 applied
        rst_n     = 1'b0;
        ptgiay_in = 7'd34;
        giay_in   = 7'd2;
        phut_in   = 7'd1;
        gio_in    = 7'd0;
        repeat (3) @(posedge ckht);
        @(negedge ckht);
        check_disp("rst_disp", 0);
        check_val("rst_viewing", int'(viewing), 0);
        check_val("rst_lap_idx", int'(lap_idx), 0);
        check_val("rst_lap_cnt", int'(lap_cnt), 0);
        check_val("rst_full",    int'(full),    0);
        check_val("rst_ovf",     int'(ovf),     0);
        rst_n  = 1'b1;
        m_view = 0;
        m_idx  = 0;
        m_ovf  = 0;
        m_laps.delete();

        do_cycle(0, 0, 0, 0, 0, 0, 6234);
        check_val("live_m", int'(phut), 1);
        check_val("live_cs", int'(ptgiay), 34);

        // Two laps, view the newest, absolute then split
        do_cycle(1, 0, 0, 0, 0, 0, 1050);
        do_cycle(1, 0, 0, 0, 0, 0, 2520);
        do_cycle(0, 1, 0, 0, 0, 0, 2600);
        check_val("view_idx", int'(lap_idx), 1);
        do_cycle(0, 0, 0, 0, 0, 0, 2700);
        check_val("abs_s", int'(giay), 25);
        check_val("abs_cs", int'(ptgiay), 20);
        do_cycle(0, 0, 0, 0, 0, 1, 2800);
        check_val("split_s", int'(giay), 14);
        check_val("split_cs", int'(ptgiay), 70);

        // Navigation with wrap in both directions
        do_cycle(0, 0, 1, 0, 0, 0, 2900);
        check_val("next0", int'(lap_idx), 0);
        do_cycle(0, 0, 1, 0, 0, 0, 3000);
        check_val("next_wrap", int'(lap_idx), 1);
        check_val("lap0_s", int'(giay), 10);
        check_val("lap0_cs", int'(ptgiay), 50);
        do_cycle(0, 0, 0, 1, 0, 0, 3100);
        check_val("prev0", int'(lap_idx), 0);
        do_cycle(0, 0, 0, 1, 0, 0, 3200);
        check_val("prev_wrap", int'(lap_idx), 1);
        do_cycle(0, 0, 1, 1, 0, 0, 3300);
        check_val("both_nomove", int'(lap_idx), 1);

        // Fill memory with 9 laps
        do_cycle(0, 0, 0, 0, 1, 0, 3400);
        for (int k = 0; k < 9; k++) do_cycle(1, 0, 0, 0, 0, 0, 100000 + k * 1111);
        check_val("fill_cnt", int'(lap_cnt), 8);
        check_val("fill_full", int'(full), 1);
        check_val("fill_ovf", int'(ovf), 1);
        do_cycle(0, 1, 0, 0, 0, 0, 120000);
        check_val("fill_idx", int'(lap_idx), 7);
        do_cycle(0, 0, 0, 0, 0, 0, 120100);
        check_val("w7_m", int'(phut), 17);
        check_val("w7_s", int'(giay), 57);
        check_val("w7_cs", int'(ptgiay), 77);

        // clr_p + lap_p in VIEW with 3 laps
        do_cycle(0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) do_cycle(1, 0, 0, 0, 0, 0, 500 + k * 300);
        do_cycle(0, 1, 0, 0, 0, 0, 1500);
        do_cycle(1, 0, 0, 0, 1, 0, 1600);
        check_val("clr_cnt", int'(lap_cnt), 0);
        check_val("clr_view", int'(viewing), 0);
        do_cycle(0, 1, 0, 0, 0, 0, 1700);
        check_val("view_empty", int'(viewing), 0);

        // Split with a full borrow chain
        do_cycle(1, 0, 0, 0, 0, 0, 359999);
        do_cycle(1, 0, 0, 0, 0, 0, 360005);
        do_cycle(0, 1, 0, 0, 0, 1, 360100);
        do_cycle(0, 0, 0, 0, 0, 1, 360200);
        check_val("borrow_cs", int'(ptgiay), 6);
        check_val("borrow_s", int'(giay), 0);
        check_val("borrow_m", int'(phut), 0);
        check_val("borrow_h", int'(gio), 0);

        // Random pulses and times
        do_cycle(0, 0, 0, 0, 1, 0, 0);
        t = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) t = $urandom_range(0, WRAP_CS - 1);
            else                           t = (t + $urandom_range(0, 3000)) % WRAP_CS;
            do_cycle($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)), t);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/luu_lap_gpg.md
# luu_lap_gpg

Lap/split memory for the sports stopwatch. It sits between the time counter and the hex-to-BCD conversion stage. It captures the running time (centiseconds, seconds, minutes, hours) on a lap request and stores up to DEPTH laps. It drives the display path with either the live time or a recalled lap, shown as an absolute or a split value.

## Interface
- DEPTH, 8: number of lap slots; power of two, 2..16.
- AW, 3: index width, log2(DEPTH).

- ckht  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- lap_p  in  1  one-cycle pulse: record current time (already debounced/edge-detected upstream).
- view_p  in  1  one-cycle pulse: toggle LIVE/VIEW.
- next_p  in  1  one-cycle pulse: next stored lap.
- prev_p  in  1  one-cycle pulse: previous stored lap.
- clr_p  in  1  one-cycle pulse: erase all laps.
- split_md  in  1  in VIEW: 0 = absolute time, 1 = split vs previous lap.
- ptgiay_in  in  7  live centiseconds, 0..99.
- giay_in  in  7  live seconds, 0..59.
- phut_in  in  7  live minutes, 0..59.
- gio_in  in  7  live hours, 0..99.
- ptgiay, giay, phut, gio  out  7 each  selected time to the BCD stage.
- viewing  out  1  1 in VIEW.
- lap_idx  out  AW  lap shown (0-based); 0 in LIVE.
- lap_cnt  out  AW+1  laps stored, 0..DEPTH.
- full  out  1  lap_cnt == DEPTH.
- ovf  out  1  sticky: a lap_p was dropped because the memory was full.

## Operation
- Storage: DEPTH x 28-bit words {gio,phut,giay,ptgiay}, written at address lap_cnt. Register array, no reset on contents.
- States: LIVE and VIEW.
  - LIVE: outputs follow the live inputs.
  - VIEW: outputs show word[lap_idx], or its split.
- Priority within a cycle: clr_p > lap_p > view_p > next_p/prev_p.
  - Lower-priority pulses in the same cycle are ignored, except that lap_p and view_p may act together.
  - next_p and prev_p together: no move.
- clr_p: lap_cnt=0, lap_idx=0, ovf=0, state LIVE.
- lap_p when lap_cnt<DEPTH: store the live time and increment lap_cnt. Allowed in both states; VIEW index is unchanged.
- lap_p when full: no write; ovf=1.
- view_p in LIVE:
  - If lap_cnt>0: go to VIEW, lap_idx=lap_cnt-1 (newest lap).
  - If lap_cnt==0: ignored.
- view_p in VIEW: go to LIVE, lap_idx=0.
- next_p in VIEW: lap_idx+1, wrapping from lap_cnt-1 to 0.
- prev_p in VIEW: lap_idx-1, wrapping from 0 to lap_cnt-1.
- next_p/prev_p in LIVE: ignored.
- Split (split_md=1): word[lap_idx] minus word[lap_idx-1]; for lap_idx=0 the subtrahend is 0.
  - Mixed-radix subtract: centiseconds mod 100, seconds mod 60, minutes mod 60, each borrowing into the next field; hours mod 100.
  - Result is always within field ranges.
  - An hours underflow cannot occur from monotonic captures. If it occurs, it wraps mod 100.

## Timing
- All outputs are registered. Displayed time lags the live inputs or the selected word by 1 cycle.
- lap_p at edge N: the word is written at edge N and lap_cnt/full update at edge N. A view_p in the same cycle that enters VIEW uses the pre-increment lap_cnt.
- The time outputs reflect a state/index/split_md change at edge N+1.
- Reset values:
  - ptgiay=giay=phut=gio=0.
  - viewing=0, lap_idx=0, lap_cnt=0, full=0, ovf=0, state LIVE.
- Reset mid-operation: state returns immediately to LIVE with empty memory. Stale words are never displayed, because VIEW requires lap_cnt>0.
- A run-reset of the upstream counter does not clear laps; only clr_p or rst_n does.

## Structure
- Shared package: field limits (100, 60, 60, 100), TIME_W=7, the state encoding (LIVE=0, VIEW=1), and the 28-bit lap-word packing order.
- Sub-module: tru_thoigian, a combinational mixed-radix subtractor (two 28-bit words in, 28-bit difference out).

## Test plan
- Reset, then live 00:01:02.34 -> outputs 0 during reset; 1 cycle after release the outputs equal the live input; lap_cnt=0.
- Laps at 00:00:10.50 and 00:00:25.20, then view_p -> viewing=1, lap_idx=1, shows 00:00:25.20. With split_md=1 shows 00:00:14.70.
- In VIEW with 2 laps: next_p -> lap_idx=0 shows 00:00:10.50; next_p -> wraps to 1; prev_p twice -> 0, then 1.
- 9 lap_p with DEPTH=8 -> lap_cnt=8, full=1, ovf=1; word 7 holds the 8th capture.
- Same-cycle clr_p+lap_p in VIEW with 3 laps -> lap_cnt=0, LIVE, ovf=0. A later view_p is ignored.
- Split borrow: laps 00:59:59.99 and 01:00:00.05, split on lap_idx=1 -> 00:00:00.06.
